// File: rtl/decision_vote.sv
// Majority vote over a window of VOTES classifier decisions, with a
// valid/ready verdict handshake, invalid-code counter and sticky drop flag.
module decision_vote #(
    parameter int VOTES = 5,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] y_i,
    input  logic       y_valid_i,
    input  logic       clear_i,
    output logic [7:0] class_o,
    output logic       class_valid_o,
    input  logic       class_ready_i,
    output logic [7:0] err_cnt_o,
    output logic       drop_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DECIDE  = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt [4];
    logic [CNT_W-1:0]   win_cnt;
    logic [7:0]         class_q;
    logic [7:0]         err_q;
    logic               drop_q;

    logic               code_ok;
    logic [1:0]         vote_idx;
    logic               last_vote;
    logic               handshake;
    logic [1:0]         best_idx;
    logic [CNT_W-1:0]   best_cnt;

    assign code_ok   = (y_i >= 8'd1) && (y_i <= 8'd4);
    assign vote_idx  = y_i[1:0] - 2'd1;
    assign last_vote = y_valid_i && code_ok && (win_cnt == CNT_W'(VOTES - 1));
    assign handshake = class_ready_i;

    // Strict '>' keeps the lower class index on ties
    always_comb begin
        best_idx = 2'd0;
        best_cnt = cnt[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if (cnt[i] > best_cnt) begin
                best_cnt = cnt[i];
                best_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = COLLECT;
        end else begin
            unique case (state)
                COLLECT: if (last_vote) state_nxt = DECIDE;
                DECIDE:  state_nxt = OUTPUT;
                OUTPUT:  if (handshake) state_nxt = COLLECT;
                default: state_nxt = COLLECT;
            endcase
        end
    end

    always_comb begin
        class_valid_o = (state == OUTPUT);
        busy_o        = (state != COLLECT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
            win_cnt <= '0;
            class_q <= '0;
            err_q   <= '0;
            drop_q  <= 1'b0;
        end else if (clear_i) begin
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
            win_cnt <= '0;
            class_q <= '0;
            err_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (state != COLLECT && y_valid_i) drop_q <= 1'b1;
            unique case (state)
                COLLECT: begin
                    if (y_valid_i) begin
                        if (code_ok) begin
                            cnt[vote_idx] <= cnt[vote_idx] + CNT_W'(1);
                            win_cnt       <= win_cnt + CNT_W'(1);
                        end else if (err_q != 8'hFF) begin
                            err_q <= err_q + 8'd1;
                        end
                    end
                end
                DECIDE: class_q <= {6'd0, best_idx} + 8'd1;
                OUTPUT: begin
                    if (handshake) begin
                        for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
                        win_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign class_o   = class_q;
    assign err_cnt_o = err_q;
    assign drop_o    = drop_q;

endmodule
